// File: rtl/vdp_bus_initiator_if.sv
// vdp_bus_initiator_if: command, response and VDP CPU-port pin bundle for the bus initiator.
interface vdp_bus_initiator_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_mode;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       done;
  logic [1:0] mode_o;
  logic       csw_n_o;
  logic       csr_n_o;
  logic [7:0] cd_o;
  logic       cd_oe;
  logic [7:0] cd_i;
  modport master (
    input  req_valid, req_write, req_mode, req_data, cd_i,
    output req_ready, rsp_valid, rsp_data, done, mode_o, csw_n_o, csr_n_o, cd_o, cd_oe
  );
  modport slave (
    output req_valid, req_write, req_mode, req_data, cd_i,
    input  req_ready, rsp_valid, rsp_data, done, mode_o, csw_n_o, csr_n_o, cd_o, cd_oe
  );
endinterface

// File: rtl/vdp_bus_initiator.sv
// vdp_bus_initiator: drives VDP CPU-port accesses with programmable setup/strobe/hold/recovery timing.
module vdp_bus_initiator #(
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 6,
  parameter int HOLD_CYC     = 2,
  parameter int RECOVERY_CYC = 4
) (
  input logic                 clk,
  input logic                 reset,
  vdp_bus_initiator_if.master bus
);
  localparam int M0   = SETUP_CYC > STROBE_CYC ? SETUP_CYC : STROBE_CYC;
  localparam int M1   = HOLD_CYC > RECOVERY_CYC ? HOLD_CYC : RECOVERY_CYC;
  localparam int MAXC = M0 > M1 ? M0 : M1;
  localparam int CW   = $clog2(MAXC + 1);
  if (SETUP_CYC < 1 || STROBE_CYC < 2 || HOLD_CYC < 1 || RECOVERY_CYC < 1) begin : g_bad_param
    $error("vdp_bus_initiator: timing parameter below its minimum");
  end
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_write, r_ready, r_rsp_valid, r_done, r_csw_n, r_csr_n, r_cd_oe;
  logic [1:0]    r_mode;
  logic [7:0]    r_cd, r_sync, r_rsp;
  logic          w_accept, w_exp, w_last;
  assign w_accept = bus.req_valid & r_ready;
  assign w_exp    = r_cnt == '0;
  assign w_last   = r_state == RECOVER && w_exp;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
    end
  end
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt - 1'b1;
    case (r_state)
      IDLE: begin
        w_next = w_accept ? SETUP : IDLE;
        w_cnt  = CW'(SETUP_CYC - 1);
      end
      SETUP:   if (w_exp) begin w_next = STROBE;  w_cnt = CW'(STROBE_CYC - 1);   end
      STROBE:  if (w_exp) begin w_next = HOLD;    w_cnt = CW'(HOLD_CYC - 1);     end
      HOLD:    if (w_exp) begin w_next = RECOVER; w_cnt = CW'(RECOVERY_CYC - 1); end
      RECOVER: if (w_exp) begin w_next = IDLE;    w_cnt = '0;                    end
      default: w_next = IDLE;
    endcase
  end
  // Pins register the decode of the next state, so every pin comes straight off a flop.
  // rsp_data acts as the second synchroniser stage, capturing cd_i as seen one cycle before strobe end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_done      <= 1'b0;
      r_csw_n     <= 1'b1;
      r_csr_n     <= 1'b1;
      r_cd_oe     <= 1'b0;
      r_write     <= 1'b0;
      r_mode      <= '0;
      r_cd        <= '0;
      r_sync      <= '0;
      r_rsp       <= '0;
    end else begin
      r_ready     <= w_next == IDLE;
      r_done      <= w_last;
      r_rsp_valid <= w_last & ~r_write;
      r_csw_n     <= !(w_next == STROBE && r_write);
      r_csr_n     <= !(w_next == STROBE && !r_write);
      r_cd_oe     <= w_accept ? bus.req_write : r_cd_oe & (w_next != RECOVER) & (w_next != IDLE);
      r_sync      <= bus.cd_i;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_mode  <= bus.req_mode;
        r_cd    <= bus.req_data;
      end
      if (r_state == STROBE && w_exp && !r_write) r_rsp <= r_sync;
    end
  end
  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp;
  assign bus.done      = r_done;
  assign bus.mode_o    = r_mode;
  assign bus.csw_n_o   = r_csw_n;
  assign bus.csr_n_o   = r_csr_n;
  assign bus.cd_o      = r_cd;
  assign bus.cd_oe     = r_cd_oe;
endmodule
